multiplier_shifter_32bit: RTL and testbench

//   Arithmetic engine for neuron membrane-potential decay: a sequential 32x32->64 shift-add

---
 rtl/multiplier_shifter_32bit_pkg.sv | 21 ++
 rtl/multiplier_shifter_32bit_if.sv | 29 ++
 rtl/multiplier_shifter_32bit_shift_core.sv | 36 +++
 rtl/multiplier_shifter_32bit.sv | 118 +++++++++++
 tb/tb_multiplier_shifter_32bit.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/multiplier_shifter_32bit_pkg.sv
// Shared constants and types for the membrane-decay arithmetic engine
// (shift-mode encodings, multiplier step count, multiplier FSM states).
package decay_arith_pkg;

  localparam int WIDTH     = 32;
  localparam int SHAMT_W   = 5;
  localparam int MUL_STEPS = 32;
  localparam int CNT_W     = $clog2(MUL_STEPS);

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/multiplier_shifter_32bit_if.sv
// Start/done handshake bundle for the multiplier and barrel shifter engines.
interface multiplier_shifter_32bit_if;
  import decay_arith_pkg::*;

  logic                 mul_start;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic [2*WIDTH-1:0]   mul_result;
  logic                 mul_done;
  logic                 mul_busy;

  logic                 sh_start;
  logic [WIDTH-1:0]     sh_data_in;
  logic [SHAMT_W-1:0]   sh_amount;
  logic [1:0]           sh_mode;
  logic [WIDTH-1:0]     sh_data_out;
  logic                 sh_done;

  modport master (
    output mul_start, mul_a, mul_b, sh_start, sh_data_in, sh_amount, sh_mode,
    input  mul_result, mul_done, mul_busy, sh_data_out, sh_done
  );

  modport slave (
    input  mul_start, mul_a, mul_b, sh_start, sh_data_in, sh_amount, sh_mode,
    output mul_result, mul_done, mul_busy, sh_data_out, sh_done
  );

endinterface

// File: rtl/multiplier_shifter_32bit_shift_core.sv
// Purely combinational logarithmic barrel shifter: LSL / LSR / ASR / ROR.
module shift_core
  import decay_arith_pkg::*;
(
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] amount_i,
  input  logic [1:0]         mode_i,
  output logic [WIDTH-1:0]   data_o
);

  // stage[k] holds the value after the amount bits below k have been applied
  logic [SHAMT_W:0][WIDTH-1:0] stage;

  assign stage[0] = data_i;

  generate
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      localparam int S = 1 << gi;
      logic [WIDTH-1:0] shifted;

      always_comb begin
        case (mode_i)
          SH_LSL:  shifted = {stage[gi][WIDTH-1-S:0], {S{1'b0}}};
          SH_LSR:  shifted = {{S{1'b0}}, stage[gi][WIDTH-1:S]};
          SH_ASR:  shifted = {{S{stage[gi][WIDTH-1]}}, stage[gi][WIDTH-1:S]};
          default: shifted = {stage[gi][S-1:0], stage[gi][WIDTH-1:S]};
        endcase
      end

      assign stage[gi+1] = amount_i[gi] ? shifted : stage[gi];
    end
  endgenerate

  assign data_o = stage[SHAMT_W];

endmodule

// File: rtl/multiplier_shifter_32bit.sv
// Decay arithmetic engine: 32-step shift-add multiplier plus registered barrel shifter.
// Define SIGNED_MUL_EN for two's-complement multiply; default build is unsigned.
module multiplier_shifter_32bit
  import decay_arith_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  multiplier_shifter_32bit_if.slave  arith_if
);

  mul_state_e          state_q, state_d;
  logic [2*WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]    mplier_q;
  logic [2*WIDTH-1:0]  acc_q;
  logic [2*WIDTH-1:0]  result_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                mul_accept;
  logic                mul_run;
  logic                last_step;
  logic [2*WIDTH-1:0]  acc_next;
  logic [2*WIDTH-1:0]  product;

  assign mul_accept = arith_if.mul_start && (state_q != MUL_RUN);
  assign mul_run    = (state_q == MUL_RUN);
  assign last_step  = mul_run && (cnt_q == CNT_W'(MUL_STEPS - 1));
  assign acc_next   = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef SIGNED_MUL_EN
  // Unsigned product minus (a<0 ? b<<32) and (b<0 ? a<<32) gives the signed product mod 2^64
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [WIDTH-1:0] corr_hi;

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (mul_accept) begin
      op_a_q <= arith_if.mul_a;
      op_b_q <= arith_if.mul_b;
    end
  end

  assign corr_hi = (op_a_q[WIDTH-1] ? op_b_q : '0) + (op_b_q[WIDTH-1] ? op_a_q : '0);
  assign product = acc_next - {corr_hi, {WIDTH{1'b0}}};
`else
  assign product = acc_next;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state_q <= MUL_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_IDLE: if (arith_if.mul_start) state_d = MUL_RUN;
      MUL_RUN:  if (last_step)          state_d = MUL_DONE;
      MUL_DONE: if (arith_if.mul_start) state_d = MUL_RUN;
      default:                          state_d = MUL_IDLE;
    endcase
  end

  always_comb begin
    arith_if.mul_busy = (state_q == MUL_RUN);
    arith_if.mul_done = (state_q == MUL_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (mul_accept) begin
      mcand_q  <= {{WIDTH{1'b0}}, arith_if.mul_a};
      mplier_q <= arith_if.mul_b;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (mul_run) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (last_step) result_q <= product;
    end
  end

  assign arith_if.mul_result = result_q;

  logic [WIDTH-1:0] sh_result;
  logic [WIDTH-1:0] sh_data_q;
  logic             sh_done_q;

  shift_core u_shift_core (
    .data_i   (arith_if.sh_data_in),
    .amount_i (arith_if.sh_amount),
    .mode_i   (arith_if.sh_mode),
    .data_o   (sh_result)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_data_q <= '0;
      sh_done_q <= 1'b0;
    end else if (arith_if.sh_start) begin
      sh_data_q <= sh_result;
      sh_done_q <= 1'b1;
    end
  end

  assign arith_if.sh_data_out = sh_data_q;
  assign arith_if.sh_done     = sh_done_q;

endmodule

// File: tb/tb_multiplier_shifter_32bit.sv
// Self-checking bench for multiplier_shifter_32bit: vector tables, directed
// corner sequences and random traffic against a behavioural model.
module tb_multiplier_shifter_32bit;
  import decay_arith_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multiplier_shifter_32bit_if bus_if();

  multiplier_shifter_32bit dut (
    .clk      (clk),
    .rst      (rst),
    .arith_if (bus_if)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  amt;
    logic [1:0]  mode;
    logic [31:0] exp;
  } sh_vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } mul_vec_t;

  sh_vec_t  sh_tab[12];
  mul_vec_t mul_tab[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b);
`ifdef SIGNED_MUL_EN
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
`else
    longint unsigned ua, ub;
    ua = a;
    ub = b;
    return ua * ub;
`endif
  endfunction

  function automatic logic [31:0] sh_model(input logic [31:0] d, input logic [4:0] n,
                                           input logic [1:0] mode);
    logic [31:0] r;
    int k;
    k = n;
    case (mode)
      SH_LSL:  r = d << k;
      SH_LSR:  r = d >> k;
      SH_ASR:  r = $signed(d) >>> k;
      default: for (int i = 0; i < 32; i++) r[i] = d[(i + k) % 32];
    endcase
    return r;
  endfunction

  task automatic do_shift(input logic [31:0] d, input logic [4:0] n, input logic [1:0] mode,
                          input logic [31:0] exp, input string name);
    @(negedge clk);
    bus_if.sh_data_in = d;
    bus_if.sh_amount  = n;
    bus_if.sh_mode    = mode;
    bus_if.sh_start   = 1'b1;
    @(negedge clk);
    bus_if.sh_start   = 1'b0;
    bus_if.sh_data_in = $urandom;
    bus_if.sh_amount  = 5'($urandom);
    bus_if.sh_mode    = 2'($urandom);
    check({name, " data"}, 64'(bus_if.sh_data_out), 64'(exp));
    check({name, " done"}, 64'(bus_if.sh_done), 64'(1));
    $display("[TB] shift %s d=%08h amt=%0d mode=%0d out=%08h", name, d, n, mode, bus_if.sh_data_out);
  endtask

  task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus_if.mul_a     = a;
    bus_if.mul_b     = b;
    bus_if.mul_start = 1'b1;
    @(negedge clk);
    bus_if.mul_start = 1'b0;
    bus_if.mul_a     = $urandom;
    bus_if.mul_b     = $urandom;
  endtask

  task automatic wait_mul(input logic [63:0] exp, input int exp_lat, input string name);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus_if.mul_done && lat < 100);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, bus_if.mul_result, exp);
    check({name, " busy"}, 64'(bus_if.mul_busy), 64'(0));
    $display("[TB] mul %s result=%016h latency=%0d", name, bus_if.mul_result, lat);
  endtask

  initial begin
    logic [31:0] ra, rb, rd;
    logic [4:0]  rn;
    logic [1:0]  rm;
    int          seen;

    sh_tab[0]  = '{32'h80000010, 5'd1,  SH_LSR, 32'h40000008};
    sh_tab[1]  = '{32'h80000010, 5'd1,  SH_ASR, 32'hC0000008};
    sh_tab[2]  = '{32'h80000010, 5'd1,  SH_LSL, 32'h00000020};
    sh_tab[3]  = '{32'h80000010, 5'd4,  SH_ROR, 32'h08000001};
    sh_tab[4]  = '{32'h80000010, 5'd0,  SH_LSL, 32'h80000010};
    sh_tab[5]  = '{32'h80000010, 5'd0,  SH_LSR, 32'h80000010};
    sh_tab[6]  = '{32'h80000010, 5'd0,  SH_ASR, 32'h80000010};
    sh_tab[7]  = '{32'h80000010, 5'd0,  SH_ROR, 32'h80000010};
    sh_tab[8]  = '{32'h80000010, 5'd31, SH_ASR, 32'hFFFFFFFF};
    sh_tab[9]  = '{32'h00000001, 5'd31, SH_LSL, 32'h80000000};
    sh_tab[10] = '{32'h80000010, 5'd31, SH_ROR, 32'h00000021};
    sh_tab[11] = '{32'h80000010, 5'd31, SH_LSR, 32'h00000001};

    mul_tab[0] = '{32'h00000010, 32'h00000010, 64'h0000000000000100};
    mul_tab[1] = '{32'h00000000, 32'hDEADBEEF, 64'h0000000000000000};
`ifdef SIGNED_MUL_EN
    mul_tab[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
    mul_tab[3] = '{32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000};
`else
    mul_tab[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    mul_tab[3] = '{32'h7FFFFFFF, 32'h80000000, 64'h3FFFFFFF80000000};
`endif

    // Reset held with both starts asserted: reset must win
    rst = 1'b0;
    bus_if.mul_start  = 1'b1;
    bus_if.mul_a      = 32'h1234;
    bus_if.mul_b      = 32'h5678;
    bus_if.sh_start   = 1'b1;
    bus_if.sh_data_in = 32'hFFFF0000;
    bus_if.sh_amount  = 5'd3;
    bus_if.sh_mode    = SH_LSR;
    repeat (3) @(negedge clk);
    check("reset mul_result", bus_if.mul_result, 64'(0));
    check("reset mul_done", 64'(bus_if.mul_done), 64'(0));
    check("reset mul_busy", 64'(bus_if.mul_busy), 64'(0));
    check("reset sh_data_out", 64'(bus_if.sh_data_out), 64'(0));
    check("reset sh_done", 64'(bus_if.sh_done), 64'(0));
    bus_if.mul_start = 1'b0;
    bus_if.sh_start  = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 12; i++)
      do_shift(sh_tab[i].data, sh_tab[i].amt, sh_tab[i].mode, sh_tab[i].exp, $sformatf("shtab%0d", i));

    for (int i = 0; i < 4; i++) begin
      start_mul(mul_tab[i].a, mul_tab[i].b);
      check($sformatf("multab%0d start busy", i), 64'(bus_if.mul_busy), 64'(1));
      check($sformatf("multab%0d start done", i), 64'(bus_if.mul_done), 64'(0));
      wait_mul(mul_tab[i].exp, 32, $sformatf("multab%0d", i));
    end

    // mul_start mid-run with other operands must be ignored
    start_mul(32'h00012345, 32'h00000777);
    repeat (4) @(negedge clk);
    bus_if.mul_a     = 32'hFFFFFFFF;
    bus_if.mul_b     = 32'h0000FFFF;
    bus_if.mul_start = 1'b1;
    @(negedge clk);
    bus_if.mul_start = 1'b0;
    wait_mul(mul_model(32'h00012345, 32'h00000777), 27, "midrun");

    // Reset at cycle 10 of a multiply aborts it without a done
    start_mul(32'hCAFEF00D, 32'h0BADBEEF);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort mul_result", bus_if.mul_result, 64'(0));
    check("abort mul_done", 64'(bus_if.mul_done), 64'(0));
    check("abort mul_busy", 64'(bus_if.mul_busy), 64'(0));
    check("abort sh_done", 64'(bus_if.sh_done), 64'(0));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus_if.mul_done) seen = 1;
    end
    check("abort no done", 64'(seen), 64'(0));
    start_mul(32'h00000005, 32'hFFFFFFFB);
    wait_mul(mul_model(32'h00000005, 32'hFFFFFFFB), 32, "after_abort");

    // Simultaneous starts on both engines
    @(negedge clk);
    bus_if.mul_a      = 32'h89ABCDEF;
    bus_if.mul_b      = 32'h13579BDF;
    bus_if.mul_start  = 1'b1;
    bus_if.sh_data_in = 32'h80000010;
    bus_if.sh_amount  = 5'd4;
    bus_if.sh_mode    = SH_ROR;
    bus_if.sh_start   = 1'b1;
    @(negedge clk);
    bus_if.mul_start  = 1'b0;
    bus_if.sh_start   = 1'b0;
    bus_if.mul_a      = $urandom;
    bus_if.sh_data_in = $urandom;
    check("simul sh data", 64'(bus_if.sh_data_out), 64'(32'h08000001));
    check("simul sh done", 64'(bus_if.sh_done), 64'(1));
    wait_mul(mul_model(32'h89ABCDEF, 32'h13579BDF), 32, "simul");
    check("simul sh held", 64'(bus_if.sh_data_out), 64'(32'h08000001));

    for (int i = 0; i < 30; i++) begin
      rd = $urandom;
      rn = 5'($urandom);
      rm = 2'($urandom);
      do_shift(rd, rn, rm, sh_model(rd, rn, rm), $sformatf("rnd_sh%0d", i));
    end

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      start_mul(ra, rb);
      wait_mul(mul_model(ra, rb), 32, $sformatf("rnd_mul%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
